// File: rtl/shunt_hs_rtl_pkg.sv
// Shared definitions for the handshake TX framer.
//   framer_state_e : framer FSM states. The header states are contiguous, so a
//                    header beat index is simply (state - H_TYPE).
//   HDR_*          : header beat indices. HDR_BEATS is the number of header beats per chunk.
package shunt_hs_rtl_pkg;
  typedef enum logic [2:0] {
    FILL    = 3'd0,
    H_TYPE  = 3'd1,
    H_ID    = 3'd2,
    H_DTYPE = 3'd3,
    H_NPAY  = 3'd4,
    PAY     = 3'd5,
    TRAIL   = 3'd6
  } framer_state_e;

  localparam int HDR_TYPE  = 0;
  localparam int HDR_ID    = 1;
  localparam int HDR_DTYPE = 2;
  localparam int HDR_NPAY  = 3;
  localparam int HDR_BEATS = 4;
endpackage

// File: rtl/shunt_hs_chunk_buf.sv
// Single chunk buffer of MAX_PAYLOAD bytes.
// The fill side writes at cnt and increments it. The drain side reads at rd.
// clr empties the buffer by resetting cnt and rd; the stored bytes are not cleared.
// Ports:
//   clk, clr       clock; synchronous clear (reset or chunk done)
//   wr_en, wr_data write one byte at position cnt
//   rd_adv         advance the read pointer
//   cnt            bytes held (1..MAX_PAYLOAD once filled)
//   rd_data        byte at the read pointer
//   rd_last        read pointer is on the final held byte
//   wr_full        the next write fills the buffer
module shunt_hs_chunk_buf #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          rd_adv,
  output logic [$clog2(MAX_PAYLOAD):0]  cnt,
  output logic [7:0]                    rd_data,
  output logic                          rd_last,
  output logic                          wr_full
);
  localparam int AW = $clog2(MAX_PAYLOAD);
  localparam logic [AW:0] FILL_LAST = (AW+1)'(MAX_PAYLOAD - 1);

  logic [7:0]    mem [MAX_PAYLOAD];
  logic [AW-1:0] rd;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      rd  <= '0;
    end else begin
      if (wr_en)  cnt <= cnt + 1'b1;
      if (rd_adv) rd  <= rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd];
  assign rd_last = ({1'b0, rd} + 1'b1) == cnt;
  assign wr_full = cnt == FILL_LAST;
endmodule

// File: rtl/shunt_hs_tx_framer.sv
// Handshake TX framer. It splits a byte message stream into chunks of at most
// MAX_PAYLOAD bytes. Each chunk is sent as 4 header beats (trnx_type, trnx_id,
// data_type, n_payloads) followed by its payload beats.
// Optional macro SHUNT_HS_FRAMER_CHKSUM_EN adds a trailer beat after the payload.
// The trailer carries the modulo-256 sum of the payload, and m_last/m_msg_last
// move onto it.
// Ports:
//   clk, rst                        clock; synchronous active-high reset
//   cfg_trnx_type, cfg_data_type    per-message header fields, latched on the first byte
//   s_valid/s_ready/s_data/s_last   byte input stream
//   m_valid/m_ready/m_data          output beat stream
//   m_hdr, m_last, m_msg_last       header beat / end of chunk / end of message
module shunt_hs_tx_framer
  import shunt_hs_rtl_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int WORD_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] cfg_trnx_type,
  input  logic [WORD_W-1:0] cfg_data_type,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_hdr,
  output logic              m_last,
  output logic              m_msg_last
);
  localparam int CW = $clog2(MAX_PAYLOAD) + 1;

  framer_state_e     state, state_nx;
  logic [WORD_W-1:0] type_q, dtype_q, id_q;
  logic              msg_start;   // next accepted byte opens a new message
  logic              msg_last_q;  // current chunk ends its message
  logic [CW-1:0]     cnt;
  logic [7:0]        rd_data;
  logic              rd_last, wr_full, rd_adv, chunk_done, acc;
  logic [WORD_W-1:0] hdr [HDR_BEATS];
  logic [1:0]        hdr_idx;

  assign acc = s_valid & s_ready;

  shunt_hs_chunk_buf #(.MAX_PAYLOAD(MAX_PAYLOAD)) u_buf (
    .clk     (clk),
    .clr     (rst | chunk_done),
    .wr_en   (acc),
    .wr_data (s_data),
    .rd_adv  (rd_adv),
    .cnt     (cnt),
    .rd_data (rd_data),
    .rd_last (rd_last),
    .wr_full (wr_full)
  );

`ifdef SHUNT_HS_FRAMER_CHKSUM_EN
  logic [7:0] csum;
  // The sum restarts on the first byte of every chunk (buffer empty).
  always_ff @(posedge clk) begin
    if (rst)      csum <= '0;
    else if (acc) csum <= (cnt == '0 ? 8'd0 : csum) + s_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      id_q       <= '0;
      type_q     <= '0;
      dtype_q    <= '0;
      msg_start  <= 1'b1;
      msg_last_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        msg_start  <= s_last;
        msg_last_q <= s_last;
        if (msg_start) begin
          type_q  <= cfg_trnx_type;
          dtype_q <= cfg_data_type;
        end
      end
      if (chunk_done && msg_last_q) id_q <= id_q + 1'b1;
    end
  end

  always_comb begin
    hdr[HDR_TYPE]  = type_q;
    hdr[HDR_ID]    = id_q;
    hdr[HDR_DTYPE] = dtype_q;
    hdr[HDR_NPAY]  = WORD_W'(cnt);
    hdr_idx        = 2'(state - H_TYPE);
  end

  always_comb begin
    state_nx   = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_hdr      = 1'b0;
    m_last     = 1'b0;
    m_msg_last = 1'b0;
    m_data     = '0;
    rd_adv     = 1'b0;
    chunk_done = 1'b0;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        if (acc && (s_last || wr_full)) state_nx = H_TYPE;
      end
      H_TYPE, H_ID, H_DTYPE, H_NPAY: begin
        m_valid = 1'b1;
        m_hdr   = 1'b1;
        m_data  = hdr[hdr_idx];
        // Header states are contiguous and H_NPAY + 1 is PAY.
        if (m_ready) state_nx = framer_state_e'(state + 3'd1);
      end
      PAY: begin
        m_valid = 1'b1;
        m_data  = WORD_W'(rd_data);
        rd_adv  = m_ready & ~rd_last;
`ifdef SHUNT_HS_FRAMER_CHKSUM_EN
        if (m_ready && rd_last) state_nx = TRAIL;
`else
        m_last     = rd_last;
        m_msg_last = rd_last & msg_last_q;
        if (m_ready && rd_last) begin
          chunk_done = 1'b1;
          state_nx   = FILL;
        end
`endif
      end
`ifdef SHUNT_HS_FRAMER_CHKSUM_EN
      TRAIL: begin
        m_valid    = 1'b1;
        m_data     = WORD_W'(csum);
        m_last     = 1'b1;
        m_msg_last = msg_last_q;
        if (m_ready) begin
          chunk_done = 1'b1;
          state_nx   = FILL;
        end
      end
`endif
      default: state_nx = FILL;
    endcase
  end
endmodule

// File: tb/tb_shunt_hs_tx_framer.sv
// Scoreboard bench for shunt_hs_tx_framer (MAX_PAYLOAD=64, WORD_W=32).
// The message model pushes the expected beats. A negedge monitor pops and
// compares them on every handshake, checks stall stability, and checks that
// s_ready is the inverse of m_valid.
module tb_shunt_hs_tx_framer;
  localparam int MAXP = 64;

  typedef struct packed {
    logic [31:0] data;
    logic        hdr;
    logic        last;
    logic        mlast;
  } beat_t;

  logic        clk, rst;
  logic [31:0] cfg_trnx_type, cfg_data_type;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        m_valid, m_ready, m_hdr, m_last, m_msg_last;
  logic [31:0] m_data;

  shunt_hs_tx_framer #(.MAX_PAYLOAD(MAXP), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .cfg_trnx_type(cfg_trnx_type), .cfg_data_type(cfg_data_type),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_hdr(m_hdr),
    .m_last(m_last), .m_msg_last(m_msg_last)
  );

  beat_t       exp_q[$];
  int          n_pass = 0, n_tot = 0;
  logic [31:0] model_id = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: manual
  logic        manual_rdy = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end

  task automatic chk(input string nm, input bit ok, input logic [34:0] act, input logic [34:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference: chunk the message, 4 header beats plus payload (plus optional trailer).
  task automatic model_msg(input logic [7:0] b[$], input logic [31:0] typ, input logic [31:0] dtyp);
    int pos = 0;
    int n = b.size();
    while (pos < n) begin
      int len = (n - pos > MAXP) ? MAXP : n - pos;
      bit ml = (pos + len == n);
      int sum = 0;
      exp_q.push_back('{typ, 1'b1, 1'b0, 1'b0});
      exp_q.push_back('{model_id, 1'b1, 1'b0, 1'b0});
      exp_q.push_back('{dtyp, 1'b1, 1'b0, 1'b0});
      exp_q.push_back('{32'(len), 1'b1, 1'b0, 1'b0});
      for (int k = 0; k < len; k++) begin
        bit lst = (k == len - 1);
        sum += b[pos + k];
`ifdef SHUNT_HS_FRAMER_CHKSUM_EN
        lst = 0;
`endif
        exp_q.push_back('{32'(b[pos + k]), 1'b0, lst, lst & ml});
      end
`ifdef SHUNT_HS_FRAMER_CHKSUM_EN
      exp_q.push_back('{32'(sum % 256), 1'b0, 1'b1, ml});
`endif
      pos += len;
    end
    model_id++;
  endtask

  task automatic send_msg(input logic [7:0] b[$], input logic [31:0] typ, input logic [31:0] dtyp, input bit rnd);
    model_msg(b, typ, dtyp);
    for (int i = 0; i < b.size(); i++) begin
      int to = 0;
      if (rnd) begin
        int g = $urandom_range(0, 2);
        s_valid = 0;
        repeat (g) begin @(posedge clk); #1; end
      end
      s_valid = 1; s_data = b[i]; s_last = (i == b.size() - 1);
      if (i == 0) begin cfg_trnx_type = typ; cfg_data_type = dtyp; end
      else if (rnd) begin cfg_trnx_type = $urandom; cfg_data_type = $urandom; end
      forever begin
        bit a;
        @(negedge clk); a = s_ready;
        @(posedge clk); #1;
        if (a) break;
        to++;
        if (to > 5000) begin
          chk("send_timeout", 0, 0, 1);
          s_valid = 0; s_last = 0;
          return;
        end
      end
    end
    s_valid = 0; s_last = 0;
  endtask

  task automatic wait_drain();
    int to = 0;
    while (exp_q.size() != 0 || m_valid) begin
      @(posedge clk); #1;
      to++;
      if (to > 5000) begin chk("drain_timeout", 0, 35'(exp_q.size()), 0); return; end
    end
  endtask

  // m_ready driver runs at posedge+2 so tasks can set manual_rdy at posedge+1.
  initial begin
    m_ready = 0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0: m_ready = 1;
        1: m_ready = 1'($urandom % 2);
        default: m_ready = manual_rdy;
      endcase
    end
  end

  // Monitor
  initial begin
    bit    pstall = 0;
    beat_t pb = '0, cur, e;
    forever begin
      @(negedge clk);
      if (rst) begin pstall = 0; continue; end
      cur = '{m_data, m_hdr, m_last, m_msg_last};
      if (pstall) chk("stall_hold", m_valid && cur == pb, {cur[34:1], m_valid}, {pb[34:1], 1'b1});
      chk("s_ready_vs_m_valid", s_ready == !m_valid, 35'(s_ready), 35'(!m_valid));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 0, cur, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat", cur == e, cur, e);
        end
      end
      pstall = m_valid && !m_ready;
      pb = cur;
    end
  end

  initial begin
    logic [7:0] bq[$];
    rst = 1; s_valid = 0; s_last = 0; s_data = 0; cfg_trnx_type = 0; cfg_data_type = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {m_valid, m_hdr, m_last, m_msg_last, m_data} == '0,
        35'({m_valid, m_hdr, m_last, m_msg_last, m_data[30:0]}), 0);
    chk("rst_s_ready", s_ready == 1, 35'(s_ready), 1);
    @(posedge clk); #1 rst = 0;

    // 1: short message
    bq = '{8'hA1, 8'hA2, 8'hA3};
    send_msg(bq, 5, 2, 0);
    // 2: 130 bytes -> 64, 64, 2
    bq.delete(); for (int i = 0; i < 130; i++) bq.push_back(8'($urandom));
    send_msg(bq, 32'h11, 32'h22, 0);
    // 3: exactly one full chunk
    bq.delete(); for (int i = 0; i < 64; i++) bq.push_back(8'($urandom));
    send_msg(bq, 32'h33, 32'h44, 0);
    // 4: random stalls, random lengths (ids 3..6)
    rdy_mode = 1;
    for (int m = 0; m < 4; m++) begin
      bq.delete(); for (int i = 0, n = $urandom_range(1, 10); i < n; i++) bq.push_back(8'($urandom));
      send_msg(bq, $urandom, $urandom, 1);
    end
    wait_drain();

    // 5: reset while the H_ID beat of trnx_id 7 is stalled
    rdy_mode = 2; manual_rdy = 0;
    bq = '{8'h5A, 8'hC3};
    send_msg(bq, 32'h77, 32'h88, 0);
    manual_rdy = 1;
    @(posedge clk); #1 manual_rdy = 0;
    @(negedge clk);
    chk("hid_before_rst", m_valid && m_hdr && m_data == 7, 35'(m_data), 7);
    @(posedge clk); #1 rst = 1;
    exp_q.delete();
    model_id = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_m_valid", m_valid == 0, 35'(m_valid), 0);
    chk("rst_mid_s_ready", s_ready == 1, 35'(s_ready), 1);
    rdy_mode = 1;
    for (int m = 0; m < 6; m++) begin
      bq.delete(); for (int i = 0, n = (m == 3) ? 70 : $urandom_range(1, 10); i < n; i++) bq.push_back(8'($urandom));
      send_msg(bq, $urandom, $urandom, 1);
    end

    // 6: checksum pattern FF 02
    rdy_mode = 0;
    bq = '{8'hFF, 8'h02};
    send_msg(bq, 9, 3, 0);
    wait_drain();
    chk("queue_empty", exp_q.size() == 0, 35'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
